// File: rtl/pipe_mux_pkg.sv
// Shared definitions for the pipelined N:1 select stage: occupancy state encoding and
// the select-width helper. Used by mux_n_sel and pipe_mux_stage (macro PIPE_MUX_ONEHOT_EN).
package pipe_mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

    // Ceiling log2; callers guarantee value >= 2 so the result is never zero.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational N:1 word select with an illegal-select flag.
// PIPE_MUX_ONEHOT_EN defined: one-hot select through an AND-OR tree; otherwise binary select.
module mux_n_sel
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
`ifdef PIPE_MUX_ONEHOT_EN
    input  logic [NUM_IN-1:0]       in_sel,
`else
    input  logic [SEL_W-1:0]        in_sel,
`endif
    output logic [WIDTH-1:0]        sel_data,
    output logic                    sel_illegal
);

`ifdef PIPE_MUX_ONEHOT_EN
    logic [WIDTH-1:0] and_or;

    // Zero or several hot bits would OR channels together, so force the word to 0 then.
    always_comb begin
        and_or = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            and_or = and_or | (in_data[k*WIDTH +: WIDTH] & {WIDTH{in_sel[k]}});
        end
        sel_illegal = !$onehot(in_sel);
        sel_data    = sel_illegal ? '0 : and_or;
    end
`else
    always_comb begin
        sel_data    = '0;
        sel_illegal = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data    = in_data[k*WIDTH +: WIDTH];
                sel_illegal = 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/pipe_mux_stage.sv
// N:1 select mux feeding a registered 2-entry skid buffer with valid/ready on both sides.
// Select encoding follows PIPE_MUX_ONEHOT_EN (one-hot when defined, binary otherwise).
module pipe_mux_stage
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
`ifdef PIPE_MUX_ONEHOT_EN
    input  logic [NUM_IN-1:0]       in_sel,
`else
    input  logic [SEL_W-1:0]        in_sel,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    occ_state_t       state;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] sel_data;
    logic             sel_illegal;
    logic             accept;
    logic             pop;

    mux_n_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .in_data     (in_data),
        .in_sel      (in_sel),
        .sel_data    (sel_data),
        .sel_illegal (sel_illegal)
    );

    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = head_q;

    // Head is the visible entry and is cleared whenever it empties, so out_data is 0
    // while out_valid is low. in_ready is computed from the next state, never from out_ready.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state     <= ST_EMPTY;
            head_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= accept && sel_illegal;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head_q    <= sel_data;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                    in_ready <= 1'b1;
                end
                ST_ONE: begin
                    if (accept && !pop) begin
                        skid_q   <= sel_data;
                        state    <= ST_TWO;
                        in_ready <= 1'b0;
                    end else if (pop && !accept) begin
                        head_q    <= '0;
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        if (accept) begin
                            head_q <= sel_data;
                        end
                        in_ready <= 1'b1;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        head_q   <= skid_q;
                        skid_q   <= '0;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    head_q    <= '0;
                    skid_q    <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mux_stage.sv
// Directed checks for pipe_mux_stage (4-input main instance, 3-input instance for illegal selects).
// Honors PIPE_MUX_ONEHOT_EN for the select encoding driven into both instances.
module tb_pipe_mux_stage;

    localparam int W = 32;
`ifdef PIPE_MUX_ONEHOT_EN
    localparam int SW  = 4;
    localparam int SW3 = 3;
`else
    localparam int SW  = 2;
    localparam int SW3 = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [4*W-1:0] in_data;
    logic [SW-1:0] in_sel;
    logic          in_valid, in_ready, out_valid, out_ready, sel_err;
    logic [W-1:0]  out_data;

    logic [3*W-1:0] in_data3;
    logic [SW3-1:0] in_sel3;
    logic           in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
    logic [W-1:0]   out_data3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_mux_stage #(.WIDTH(W), .NUM_IN(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .sel_err(sel_err)
    );

    pipe_mux_stage #(.WIDTH(W), .NUM_IN(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .flush(flush), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .sel_err(sel_err3)
    );

    function automatic logic [SW-1:0] enc(input int k);
`ifdef PIPE_MUX_ONEHOT_EN
        return SW'(1) << k;
`else
        return SW'(k);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Place value on channel k and filler elsewhere.
    task automatic load(input int k, input logic [W-1:0] v);
        for (int c = 0; c < 4; c++) in_data[c*W +: W] = ~v ^ W'(c);
        in_data[k*W +: W] = v;
        in_sel = enc(k);
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_sel = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; in_data3 = '0; in_sel3 = '0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_selerr: got %b expected 0", sel_err); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        load(2, 32'hDEADBEEF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_data: got %h expected deadbeef", out_data); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_gone: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL single_zero: got %h expected 0", out_data); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        load(0, 32'd1); in_valid = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready1: got %b expected 1", in_ready); end
        load(3, 32'd2);
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready2: got %b expected 0", in_ready); end
        checks++; if (out_data !== 32'd1) begin errors++; $display("[TB] FAIL bp_hold: got %h expected 1", out_data); end
        step();
        checks++; if (out_data !== 32'd1 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable: got %h/%b expected 1/1", out_data, out_valid); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 32'd2 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second: got %h/%b expected 2/1", out_data, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready3: got %b expected 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_illegal_sel();
`ifdef PIPE_MUX_ONEHOT_EN
        out_ready = 1'b1;
        load(1, 32'h1234_5678);
        in_sel = 4'b0110;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0) begin errors++; $display("[TB] FAIL ill_entry: got %h/%b expected 0/1", out_data, out_valid); end
        checks++; if (sel_err !== 1'b1) begin errors++; $display("[TB] FAIL ill_err: got %b expected 1", sel_err); end
        step();
        checks++; if (sel_err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ill_pulse: got %b/%b expected 0/0", sel_err, out_valid); end
`else
        out_ready3 = 1'b1;
        in_data3 = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        in_sel3 = 2'd3;
        in_valid3 = 1'b1;
        step();
        in_valid3 = 1'b0;
        checks++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h0) begin errors++; $display("[TB] FAIL ill_entry: got %h/%b expected 0/1", out_data3, out_valid3); end
        checks++; if (sel_err3 !== 1'b1) begin errors++; $display("[TB] FAIL ill_err: got %b expected 1", sel_err3); end
        step();
        checks++; if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0) begin errors++; $display("[TB] FAIL ill_pulse: got %b/%b expected 0/0", sel_err3, out_valid3); end
        in_sel3 = 2'd2;
        in_valid3 = 1'b1;
        step();
        in_valid3 = 1'b0;
        checks++; if (out_data3 !== 32'hCCCC_0002 || sel_err3 !== 1'b0) begin errors++; $display("[TB] FAIL legal3: got %h/%b expected cccc0002/0", out_data3, sel_err3); end
        step();
`endif
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        load(0, 32'h11); in_valid = 1'b1; step();
        load(1, 32'h22); step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fl_full: got %b expected 0", in_ready); end
        load(2, 32'h33); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sel_err !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("[TB] FAIL fl_two: got v%b r%b e%b d%h expected v0 r1 e0 d0", out_valid, in_ready, sel_err, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_leak: got %b expected 0 at cycle %0d", out_valid, i); end
        end
        out_ready = 1'b0;
        load(3, 32'h44); in_valid = 1'b1; step();
        load(0, 32'h55); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fl_one: got v%b r%b expected v0 r1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            load(i % 4, W'(i));
            in_valid = 1'b1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream_ready: got %b expected 1 at %0d", in_ready, i); end
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin errors++; $display("[TB] FAIL stream_data: got %h/%b expected %h/1", out_data, out_valid, i); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_random_ready();
        logic [W-1:0] q[$];
        int sent = 0;
        int rcvd = 0;
        int cyc = 0;
        logic acc, pp;
        while (rcvd < 50 && cyc < 2000) begin
            in_valid = (sent < 50);
            load(sent % 4, 32'd1000 + W'(sent));
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            pp = out_valid && out_ready;
            if (pp) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("[TB] FAIL rnd_extra: got %h expected no entry", out_data); end
                else begin
                    if (out_data !== q[0]) begin errors++; $display("[TB] FAIL rnd_order: got %h expected %h", out_data, q[0]); end
                    void'(q.pop_front());
                end
                rcvd++;
            end
            if (acc) begin
                q.push_back(32'd1000 + W'(sent));
                sent++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (rcvd !== 50) begin errors++; $display("[TB] FAIL rnd_count: got %0d expected 50", rcvd); end
        out_ready = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        load(1, 32'hABCD); in_valid = 1'b1; step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hABCD) begin errors++; $display("[TB] FAIL mr_one: got %h/%b expected abcd/1", out_data, out_valid); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL mr_clear: got v%b d%h r%b expected v0 d0 r1", out_valid, out_data, in_ready); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_illegal_sel();
        test_flush();
        test_back_to_back();
        test_random_ready();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
